// File: rtl/expand.sv
// expand: rescales m-bit signed samples to n bits and emits 2^r samples per input,
// linearly ramped from the previous sample or held, with valid/ready on both sides.
module expand #(
    parameter int m = 8,
    parameter int n = 16,
    parameter int r = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [m-1:0] in,
    input  logic                in_v,
    output logic                in_r,
    input  logic                interp,
    output logic signed [n-1:0] out,
    output logic                out_v,
    input  logic                out_r
);
    localparam int w = n + 1 + r;
    localparam logic [r:0] kk = (r + 1)'(1 << r);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [r:0] k;
    logic mode;
    logic signed [n-1:0] prev, x, xn, base;
    logic signed [n:0] diff, diff_new;
    logic signed [w-1:0] acc, acc_first, acc_step;
    logic last, take;
    assign last = k == kk;
    assign in_r = state == IDLE || (last && out_r);
    assign take = in_v && in_r;
    assign xn = n'(in) <<< (n - m);
    // A new ramp starts from the last held target, even when chained back-to-back.
    assign base = state == IDLE ? prev : x;
    assign diff_new = (n + 1)'(xn) - (n + 1)'(base);
    assign acc_first = w'(diff_new);
    assign acc_step = acc + w'(diff);
    // Truncating the shifted accumulator to n bits is exact modulo 2^n,
    // and the ramp value always lies between prev and x.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            out_v <= 1'b0;
            k     <= '0;
            prev  <= '0;
            x     <= '0;
            diff  <= '0;
            acc   <= '0;
            mode  <= 1'b0;
        end else if (take) begin
            state <= RUN;
            x     <= xn;
            diff  <= diff_new;
            acc   <= acc_first;
            mode  <= interp;
            prev  <= base;
            k     <= (r + 1)'(1);
            out   <= interp ? base + n'(acc_first >>> r) : xn;
            out_v <= 1'b1;
        end else if (state == RUN && out_r) begin
            if (!last) begin
                acc <= acc_step;
                k   <= k + (r + 1)'(1);
                out <= mode ? prev + n'(acc_step >>> r) : x;
            end else begin
                prev  <= x;
                state <= IDLE;
                out_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_expand.sv
// tb_expand: table vectors, hand sequences and a randomized scoreboard run for expand.
module tb_expand;
    logic clk = 0;
    always #5 clk = ~clk;
    logic rst_n;
    logic signed [7:0] in, in8, in0;
    logic in_v, in_r, interp, out_v, out_r;
    logic in_v8, in_r8, interp8, out_v8, out_r8;
    logic in_v0, in_r0, interp0, out_v0, out_r0;
    logic signed [15:0] out, out0;
    logic signed [7:0] out8;
    int errs = 0, checks = 0;

    expand #(.m(8), .n(16), .r(2)) dut (.clk(clk), .rst_n(rst_n), .in(in), .in_v(in_v), .in_r(in_r),
        .interp(interp), .out(out), .out_v(out_v), .out_r(out_r));
    expand #(.m(8), .n(8), .r(2)) dut8 (.clk(clk), .rst_n(rst_n), .in(in8), .in_v(in_v8), .in_r(in_r8),
        .interp(interp8), .out(out8), .out_v(out_v8), .out_r(out_r8));
    expand #(.m(8), .n(16), .r(0)) dut0 (.clk(clk), .rst_n(rst_n), .in(in0), .in_v(in_v0), .in_r(in_r0),
        .interp(interp0), .out(out0), .out_v(out_v0), .out_r(out_r0));

    typedef struct {
        int x;
        bit ip;
        int e[4];
    } vec_t;
    vec_t tab[5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference ramp value: prev + floor(k*(X-prev)/K), or X when holding.
    function automatic int ramp(input int prev, input int xv, input bit ip, input int k, input int kf);
        int p, q;
        p = k * (xv - prev);
        q = p / kf;
        if (p % kf != 0 && p < 0) q--;
        return ip ? prev + q : xv;
    endfunction

    task automatic do_reset();
        rst_n = 0;
        in_v = 0; in_v8 = 0; in_v0 = 0;
        out_r = 1; out_r8 = 1; out_r0 = 1;
        interp = 1; interp8 = 1; interp0 = 1;
        in = 0; in8 = 0; in0 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_v", out_v, 0);
        chk("rst_out", out, 0);
        chk("rst_in_r", in_r, 1);
        rst_n = 1;
    endtask

    initial begin
        int q[$];
        int prev, xv, e8[12];
        bit mi_r;
        tab[0] = '{x: 4, ip: 1, e: '{256, 512, 768, 1024}};
        tab[1] = '{x: -4, ip: 1, e: '{512, 0, -512, -1024}};
        tab[2] = '{x: 127, ip: 1, e: '{7360, 15744, 24128, 32512}};
        tab[3] = '{x: -128, ip: 1, e: '{16192, -128, -16448, -32768}};
        tab[4] = '{x: 10, ip: 0, e: '{2560, 2560, 2560, 2560}};
        e8 = '{0, 1, 2, 3, 2, 1, 0, 0, -1, -2, -3, -3};

        // back-to-back table stream: every cycle must carry a valid output
        do_reset();
        in_v = 1; in = 8'(tab[0].x); interp = tab[0].ip;
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    if (i < 4) begin
                        in = 8'(tab[i + 1].x);
                        interp = tab[i + 1].ip;
                    end else in_v = 0;
                end
                #1;
                chk("tab_out_v", out_v, 1);
                chk($sformatf("tab_out[%0d][%0d]", i, k), out, tab[i].e[k]);
                if (k == 3 && i < 4) chk("tab_in_r", in_r, 1);
            end
        @(negedge clk);
        chk("tab_starve_out_v", out_v, 0);

        // backpressure after output 2
        do_reset();
        in = 4; interp = 1; in_v = 1;
        @(negedge clk);
        in_v = 0;
        chk("bp_out1", out, 256);
        @(negedge clk);
        chk("bp_out2", out, 512);
        out_r = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_out", out, 512);
            chk("bp_hold_out_v", out_v, 1);
            chk("bp_hold_in_r", in_r, 0);
        end
        out_r = 1;
        @(negedge clk);
        chk("bp_out3", out, 768);
        @(negedge clk);
        chk("bp_out4", out, 1024);
        @(negedge clk);
        chk("bp_end_out_v", out_v, 0);

        // reset mid-ramp discards the partial ramp and prev
        do_reset();
        in = 4; in_v = 1;
        @(negedge clk);
        in_v = 0;
        @(negedge clk);
        chk("mr_out2", out, 512);
        rst_n = 0;
        @(negedge clk);
        chk("mr_out_v", out_v, 0);
        chk("mr_out", out, 0);
        chk("mr_in_r", in_r, 1);
        rst_n = 1;
        in = 1; in_v = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_v = 0;
            chk("mr_ramp", out, 64 * k);
        end

        // m=n=8 floor rounding
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in8 = i == 0 ? 8'sd3 : (i == 1 ? 8'sd0 : -8'sd3);
            in_v8 = 1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                in_v8 = 0;
                chk($sformatf("n8_out[%0d]", i * 4 + k), out8, e8[i * 4 + k]);
            end
        end

        // r=0: one output per input, in_r follows out_r
        do_reset();
        in0 = 3; in_v0 = 1;
        @(negedge clk);
        #1;
        chk("r0_out_a", out0, 768);
        chk("r0_in_r_a", in_r0, 1);
        in0 = -128;
        @(negedge clk);
        in_v0 = 0; out_r0 = 0;
        #1;
        chk("r0_out_b", out0, -32768);
        chk("r0_in_r_stall", in_r0, 0);
        @(negedge clk);
        chk("r0_hold", out0, -32768);
        chk("r0_hold_v", out_v0, 1);
        out_r0 = 1;
        #1;
        chk("r0_in_r_go", in_r0, 1);
        @(negedge clk);
        chk("r0_idle_v", out_v0, 0);

        // randomized scoreboard run
        do_reset();
        prev = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_v = 1'($urandom_range(0, 1));
            in = 8'($urandom);
            interp = 1'($urandom);
            out_r = $urandom_range(0, 3) != 0;
            #1;
            mi_r = q.size() == 0 || (q.size() == 1 && out_r);
            chk("rnd_out_v", out_v, int'(q.size() != 0));
            chk("rnd_in_r", in_r, int'(mi_r));
            if (q.size() != 0 && out_r) chk("rnd_out", out, q.pop_front());
            if (in_v && mi_r) begin
                xv = int'(in) * 256;
                for (int k = 1; k <= 4; k++) q.push_back(ramp(prev, xv, interp, k, 4));
                prev = xv;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
